mem_bus_arbiter: RTL and testbench

//  Shares the single memory bus (BlockRAM and memory-mapped LEDPanel) between two masters:

---
 rtl/mem_bus_arbiter_pkg.sv | 24 ++
 rtl/mem_bus_arbiter_hold_counter.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// ============================================================================
// mem_bus_arbiter_pkg : owner encoding and default bus widths.   Rev 1.0
// ============================================================================
`default_nettype none

package mem_bus_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 19;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_A    = 2'd1,
    OWNER_B    = 2'd2
  } owner_e;

  // The competing master for a given owner; NONE maps to A so ties resolve sanely.
  function automatic owner_e other_owner(input owner_e owner);
    return (owner == OWNER_A) ? OWNER_B : OWNER_A;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_hold_counter.sv
// ============================================================================
// arb_hold_counter : counts consecutive locked retentions of the bus owner. Rev 1.0
// ============================================================================
`default_nettype none

module arb_hold_counter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_incr,
  output logic o_at_limit
);

  localparam int unsigned          c_CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [c_CNT_W-1:0]   c_LIMIT = c_CNT_W'(MAX_HOLD - 1);

  logic [c_CNT_W-1:0] r_count;

  // Saturates at the limit so MAX_HOLD=1 keeps the count pinned at zero.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_incr && !o_at_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_at_limit = (r_count == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : two-master round-robin bus arbiter with lock and parking. Rev 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_HOLD = 16,
  parameter bit          PARK     = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic              i_a_lock,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_ack,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic              i_b_lock,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_b_ack,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_owner
);

  owner_e r_owner;
  owner_e r_rr_next;

  logic w_own_req;
  logic w_own_lock;
  logic w_oth_req;
  logic w_at_limit;
  logic w_keep_locked;

  always_comb begin
    w_own_req  = 1'b0;
    w_own_lock = 1'b0;
    w_oth_req  = 1'b0;
    case (r_owner)
      OWNER_A: begin
        w_own_req  = i_a_req;
        w_own_lock = i_a_lock;
        w_oth_req  = i_b_req;
      end
      OWNER_B: begin
        w_own_req  = i_b_req;
        w_own_lock = i_b_lock;
        w_oth_req  = i_a_req;
      end
      default: ;
    endcase
  end

  assign w_keep_locked = (r_owner != OWNER_NONE) && w_own_req && w_own_lock && !w_at_limit;

  arb_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (!w_keep_locked),
    .i_incr     (w_keep_locked),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner   <= OWNER_NONE;
      r_rr_next <= OWNER_A;
    end else begin
      case (r_owner)
        OWNER_NONE: begin
          if (i_a_req && i_b_req) begin
            r_owner   <= r_rr_next;
            r_rr_next <= other_owner(r_rr_next);
          end else if (i_a_req) begin
            r_owner <= OWNER_A;
          end else if (i_b_req) begin
            r_owner <= OWNER_B;
          end
        end
        default: begin
          // A waiting competitor wins once the lock is absent or exhausted.
          if (!w_keep_locked) begin
            if (w_oth_req) begin
              r_owner   <= other_owner(r_owner);
              r_rr_next <= r_owner;
            end else if (!w_own_req && !PARK) begin
              r_owner <= OWNER_NONE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_we    = 1'b0;
    o_a_ack     = 1'b0;
    o_b_ack     = 1'b0;
    o_a_rdata   = '0;
    o_b_rdata   = '0;
    case (r_owner)
      OWNER_A: begin
        o_mem_addr  = i_a_addr;
        o_mem_wdata = i_a_wdata;
        o_mem_we    = i_a_req && i_a_we;
        o_a_ack     = i_a_req;
        o_a_rdata   = i_mem_rdata;
      end
      OWNER_B: begin
        o_mem_addr  = i_b_addr;
        o_mem_wdata = i_b_wdata;
        o_mem_we    = i_b_req && i_b_we;
        o_b_ack     = i_b_req;
        o_b_rdata   = i_mem_rdata;
      end
      default: ;
    endcase
    // A transfer coinciding with reset never completes.
    if (reset) begin
      o_mem_we = 1'b0;
      o_a_ack  = 1'b0;
      o_b_ack  = 1'b0;
    end
  end

  assign o_owner = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : directed bench for a parked and an unparked arbiter. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  localparam int unsigned MAXH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [18:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;

  logic        a_ack_o   [2];
  logic        b_ack_o   [2];
  logic [7:0]  a_rdata_o [2];
  logic [7:0]  b_rdata_o [2];
  logic [18:0] mem_addr_o[2];
  logic        mem_we_o  [2];
  logic [7:0]  mem_wd_o  [2];
  logic [7:0]  mem_rd    [2];
  logic [1:0]  owner_o   [2];

  logic [7:0]  env_mem [2][65536];
  logic [7:0]  exp_mem [2][65536];

  int m_own [2] = '{0, 0};
  int m_rr  [2] = '{1, 1};
  int m_hold[2] = '{0, 0};

  int n_checks = 0;
  int n_errors = 0;
  int t2_own[5] = '{0, 1, 2, 1, 2};
  logic [9:0] t3_a = 10'b1111011110;
  logic [9:0] t3_b = 10'b0000100000;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.ADDR_W(19), .DATA_W(8), .MAX_HOLD(MAXH), .PARK(1'b1)) dut (
    .clock(clock), .reset(reset),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_lock(a_lock), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_ack(a_ack_o[0]), .o_a_rdata(a_rdata_o[0]),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_lock(b_lock), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_ack(b_ack_o[0]), .o_b_rdata(b_rdata_o[0]),
    .o_mem_addr(mem_addr_o[0]), .o_mem_we(mem_we_o[0]), .o_mem_wdata(mem_wd_o[0]),
    .i_mem_rdata(mem_rd[0]), .o_owner(owner_o[0])
  );

  mem_bus_arbiter #(.ADDR_W(19), .DATA_W(8), .MAX_HOLD(MAXH), .PARK(1'b0)) dut_np (
    .clock(clock), .reset(reset),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_lock(a_lock), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_ack(a_ack_o[1]), .o_a_rdata(a_rdata_o[1]),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_lock(b_lock), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_ack(b_ack_o[1]), .o_b_rdata(b_rdata_o[1]),
    .o_mem_addr(mem_addr_o[1]), .o_mem_we(mem_we_o[1]), .o_mem_wdata(mem_wd_o[1]),
    .i_mem_rdata(mem_rd[1]), .o_owner(owner_o[1])
  );

  assign mem_rd[0] = env_mem[0][mem_addr_o[0][15:0]];
  assign mem_rd[1] = env_mem[1][mem_addr_o[1][15:0]];

  // Memory seen by each arbiter: async read, write at the clock edge.
  initial begin
    for (int i = 0; i < 65536; i++) begin
      env_mem[0][i] = i[7:0] ^ 8'hA5;
      env_mem[1][i] = i[7:0] ^ 8'hA5;
    end
    forever begin
      @(posedge clock);
      for (int k = 0; k < 2; k++)
        if (mem_we_o[k]) env_mem[k][mem_addr_o[k][15:0]] <= mem_wd_o[k];
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, k, act, exp);
    end
  endtask

  // Reference behaviour: outputs follow the current owner; ownership then moves by the arbitration rules.
  task automatic model_cycle(input int k);
    logic [18:0] e_addr;
    logic [7:0]  e_wd, e_ard, e_brd;
    logic        e_we, e_aa, e_ba, x_req, x_lock, y_req;
    int          x;
    e_addr = '0; e_wd = '0; e_we = 1'b0; e_aa = 1'b0; e_ba = 1'b0; e_ard = '0; e_brd = '0;
    if (m_own[k] == 1) begin
      e_addr = a_addr; e_wd = a_wdata; e_we = a_req & a_we; e_aa = a_req;
      e_ard = exp_mem[k][a_addr[15:0]];
    end else if (m_own[k] == 2) begin
      e_addr = b_addr; e_wd = b_wdata; e_we = b_req & b_we; e_ba = b_req;
      e_brd = exp_mem[k][b_addr[15:0]];
    end
    if (reset) begin
      e_we = 1'b0; e_aa = 1'b0; e_ba = 1'b0;
    end
    check("owner", k, 32'(owner_o[k]), m_own[k]);
    check("a_ack", k, 32'(a_ack_o[k]), 32'(e_aa));
    check("b_ack", k, 32'(b_ack_o[k]), 32'(e_ba));
    check("mem_we", k, 32'(mem_we_o[k]), 32'(e_we));
    check("mem_addr", k, 32'(mem_addr_o[k]), 32'(e_addr));
    check("mem_wdata", k, 32'(mem_wd_o[k]), 32'(e_wd));
    check("a_rdata", k, 32'(a_rdata_o[k]), 32'(e_ard));
    check("b_rdata", k, 32'(b_rdata_o[k]), 32'(e_brd));
    if (e_we) exp_mem[k][e_addr[15:0]] = e_wd;

    if (reset) begin
      m_own[k] = 0; m_rr[k] = 1; m_hold[k] = 0;
    end else if (m_own[k] == 0) begin
      if (a_req && b_req) begin
        m_own[k] = m_rr[k]; m_rr[k] = 3 - m_rr[k];
      end else if (a_req) m_own[k] = 1;
      else if (b_req) m_own[k] = 2;
      m_hold[k] = 0;
    end else begin
      x      = m_own[k];
      x_req  = (x == 1) ? a_req  : b_req;
      x_lock = (x == 1) ? a_lock : b_lock;
      y_req  = (x == 1) ? b_req  : a_req;
      if (x_req && x_lock && m_hold[k] < int'(MAXH) - 1) begin
        m_hold[k]++;
      end else begin
        m_hold[k] = 0;
        if (y_req) begin
          m_own[k] = 3 - x; m_rr[k] = x;
        end else if (!x_req && k == 1) begin
          m_own[k] = 0;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      exp_mem[0][i] = i[7:0] ^ 8'hA5;
      exp_mem[1][i] = i[7:0] ^ 8'hA5;
    end
    @(posedge clock);
    forever begin
      @(negedge clock);
      model_cycle(0);
      model_cycle(1);
    end
  end

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input logic req, input logic we, input logic lock, input logic [18:0] addr, input logic [7:0] d);
    a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = d;
  endtask

  task automatic set_b(input logic req, input logic we, input logic lock, input logic [18:0] addr, input logic [7:0] d);
    b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = d;
  endtask

  initial begin
    int idx;
    reset = 1'b1;
    set_a(1'b0, 1'b0, 1'b0, 19'h0, 8'h0);
    set_b(1'b0, 1'b0, 1'b0, 19'h0, 8'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Single master from NONE: one cycle of arbitration, then zero-latency reads.
    set_a(1'b1, 1'b0, 1'b0, 19'h00010, 8'h0);
    @(negedge clock);
    check("t1_owner_arb", 0, 32'(owner_o[0]), 0);
    check("t1_ack_arb", 0, 32'(a_ack_o[0]), 0);
    nxt();
    @(negedge clock);
    check("t1_owner_a", 0, 32'(owner_o[0]), 1);
    check("t1_ack", 0, 32'(a_ack_o[0]), 1);
    check("t1_rdata", 0, 32'(a_rdata_o[0]), 32'h0B5);
    nxt();
    a_addr = 19'h00011;
    @(negedge clock);
    check("t1_b2b_ack", 0, 32'(a_ack_o[0]), 1);
    check("t1_b2b_rdata", 0, 32'(a_rdata_o[0]), 32'h0B4);

    // Parking versus return-to-NONE after A goes idle.
    nxt();
    set_a(1'b0, 1'b0, 1'b0, 19'h0, 8'h0);
    @(negedge clock);
    check("t4_owner_idle1", 1, 32'(owner_o[1]), 1);
    nxt();
    @(negedge clock);
    check("t4_park_keep", 0, 32'(owner_o[0]), 1);
    check("t4_nopark_none", 1, 32'(owner_o[1]), 0);
    repeat (3) nxt();
    set_a(1'b1, 1'b0, 1'b0, 19'h00012, 8'h0);
    @(negedge clock);
    check("t4_park_ack", 0, 32'(a_ack_o[0]), 1);
    check("t4_park_rdata", 0, 32'(a_rdata_o[0]), 32'h0B7);
    check("t4_nopark_wait", 1, 32'(a_ack_o[1]), 0);
    nxt();
    @(negedge clock);
    check("t4_nopark_ack", 1, 32'(a_ack_o[1]), 1);
    check("t4_nopark_rdata", 1, 32'(a_rdata_o[1]), 32'h0B7);
    nxt();
    set_a(1'b0, 1'b0, 1'b0, 19'h0, 8'h0);
    reset = 1'b1;
    nxt();
    reset = 1'b0;

    // Contested requests from NONE alternate A,B,A,B.
    set_a(1'b1, 1'b0, 1'b0, 19'h00020, 8'h0);
    set_b(1'b1, 1'b0, 1'b0, 19'h00030, 8'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t2_owner", 0, 32'(owner_o[0]), t2_own[i]);
      check("t2_a_ack", 0, 32'(a_ack_o[0]), 32'(t2_own[i] == 1));
      check("t2_b_ack", 0, 32'(b_ack_o[0]), 32'(t2_own[i] == 2));
      if (i == 1) check("t2_a_rdata", 0, 32'(a_rdata_o[0]), 32'h085);
      if (i == 2) check("t2_b_rdata", 0, 32'(b_rdata_o[0]), 32'h095);
      nxt();
    end
    set_a(1'b0, 1'b0, 1'b0, 19'h0, 8'h0);
    set_b(1'b0, 1'b0, 1'b0, 19'h0, 8'h0);
    reset = 1'b1;
    nxt();
    reset = 1'b0;

    // Locked A burst capped at MAX_HOLD while B waits.
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      set_a(1'b1, 1'b1, 1'b1, 19'h0FF00 + idx[18:0], 8'h10 + idx[7:0]);
      set_b(i <= 5, 1'b1, 1'b0, 19'h0FF10, 8'h77);
      @(negedge clock);
      check("t3_a_ack", 0, 32'(a_ack_o[0]), 32'(t3_a[i]));
      check("t3_b_ack", 0, 32'(b_ack_o[0]), 32'(t3_b[i]));
      if (t3_a[i]) idx++;
      nxt();
    end
    set_a(1'b0, 1'b0, 1'b0, 19'h0, 8'h0);
    set_b(1'b0, 1'b0, 1'b0, 19'h0, 8'h0);
    @(negedge clock);
    for (int j = 0; j < 8; j++)
      check("t3_mem_a", 0, 32'(env_mem[0][16'hFF00 + j[15:0]]), 32'(8'h10 + j[7:0]));
    check("t3_mem_b", 0, 32'(env_mem[0][16'hFF10]), 32'h077);
    nxt();

    // Reset lands on a granted B write.
    set_b(1'b1, 1'b1, 1'b1, 19'h0FF20, 8'hC3);
    @(negedge clock);
    check("t5_b_wait", 0, 32'(b_ack_o[0]), 0);
    nxt();
    reset = 1'b1;
    @(negedge clock);
    check("t5_owner_in_rst", 0, 32'(owner_o[0]), 2);
    check("t5_ack_in_rst", 0, 32'(b_ack_o[0]), 0);
    check("t5_we_in_rst", 0, 32'(mem_we_o[0]), 0);
    check("t5_we_in_rst", 1, 32'(mem_we_o[1]), 0);
    nxt();
    reset = 1'b0;
    @(negedge clock);
    check("t5_owner_after", 0, 32'(owner_o[0]), 0);
    check("t5_owner_after", 1, 32'(owner_o[1]), 0);
    check("t5_mem_kept", 0, 32'(env_mem[0][16'hFF20]), 32'h085);
    nxt();
    @(negedge clock);
    check("t5_rearb_ack", 0, 32'(b_ack_o[0]), 1);

    // Write by B is visible to the following A read.
    nxt();
    set_b(1'b1, 1'b1, 1'b0, 19'h0FF01, 8'h5A);
    @(negedge clock);
    check("t6_b_ack", 0, 32'(b_ack_o[0]), 1);
    nxt();
    set_b(1'b0, 1'b0, 1'b0, 19'h0, 8'h0);
    set_a(1'b1, 1'b0, 1'b0, 19'h0FF01, 8'h0);
    @(negedge clock);
    check("t6_a_wait", 0, 32'(a_ack_o[0]), 0);
    nxt();
    @(negedge clock);
    check("t6_a_ack", 0, 32'(a_ack_o[0]), 1);
    check("t6_a_rdata", 0, 32'(a_rdata_o[0]), 32'h05A);
    nxt();
    set_a(1'b0, 1'b0, 1'b0, 19'h0, 8'h0);
    repeat (3) nxt();

    check("end_mem_ff20", 0, 32'(env_mem[0][16'hFF20]), 32'h0C3);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j <= 32; j++)
        check("end_mem_model", k, 32'(env_mem[k][16'hFF00 + j[15:0]]), 32'(exp_mem[k][16'hFF00 + j[15:0]]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
